bip_control: RTL and testbench

- Control unit for the BIP accumulator processor. Fetches 16-bit instructions from a synchronous-read program memory, decodes opcode[15:11] and operand[10:0], and sequences the accumulator datapath and the synchronous data RAM.
- Runs a 3-state-per-instruction FSM from a start pulse until HLT, then reports done together with a cycle count.

---
 rtl/bip_pkg.sv | 46 ++++
 rtl/bip_if.sv | 43 ++++
 rtl/bip_decoder.sv | 67 ++++++
 rtl/bip_control.sv | 161 ++++++++++++++++
 tb/tb_bip_control.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bip_pkg
//  Description : Shared definitions for the BIP control unit. This package
//                holds the opcode map, the accumulator source selects, the
//                FSM state encoding and the decoded-control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

  // Opcode map (instruction bits [15:11])
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Decoded control bundle for one opcode
  typedef struct packed {
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_code;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_if.sv
`default_nettype none
// ============================================================================
//  Module      : bip_if
//  Description : Memory bus between the BIP control unit and its program
//                memory / data RAM.
//                  pc          - program memory address
//                  instruction - program memory read data (1-cycle latency)
//                  data_addr   - data RAM address
//                  rd_ram      - data RAM read enable
//                  wr_ram      - data RAM write enable
//                master = control unit, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bip_if #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10
);

  logic [LOG2_N_INSMEM_ADDR-1:0] pc;
  logic [NB_DATA-1:0]            instruction;
  logic [LOG2_N_DATA_ADDR-1:0]   data_addr;
  logic                          rd_ram;
  logic                          wr_ram;

  modport master (
    output pc,
    output data_addr,
    output rd_ram,
    output wr_ram,
    input  instruction
  );

  modport slave (
    input  pc,
    input  data_addr,
    input  rd_ram,
    input  wr_ram,
    output instruction
  );

endinterface : bip_if
`default_nettype wire

// File: rtl/bip_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bip_decoder
//  Description : Purely combinational opcode decoder. Maps an opcode to the
//                datapath/RAM control bundle. The caller gates the result
//                by FSM state.
//  Ports       : i_opcode - opcode field
//                o_ctrl   - {wr_acc, sel_a, sel_b, op_code, wr_ram, rd_ram}
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE = 5
) (
  input  logic [NB_OPCODE-1:0] i_opcode,
  output ctrl_t                o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_STO: begin
        o_ctrl.wr_ram = 1'b1;
      end
      OP_LD: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_MEM;
        o_ctrl.rd_ram = 1'b1;
      end
      OP_LDI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SEL_A_IMM;
      end
      OP_ADD: begin
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SEL_A_ALU;
        o_ctrl.sel_b   = 1'b0;
        o_ctrl.op_code = 1'b1;
        o_ctrl.rd_ram  = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SEL_A_ALU;
        o_ctrl.sel_b   = 1'b1;
        o_ctrl.op_code = 1'b1;
      end
      OP_SUB: begin
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SEL_A_ALU;
        o_ctrl.sel_b   = 1'b0;
        o_ctrl.op_code = 1'b0;
        o_ctrl.rd_ram  = 1'b1;
      end
      OP_SUBI: begin
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SEL_A_ALU;
        o_ctrl.sel_b   = 1'b1;
        o_ctrl.op_code = 1'b0;
      end
      // HLT and every unassigned opcode: no enables
      default: o_ctrl = '0;
    endcase
  end

endmodule : bip_decoder
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
//  Module      : bip_control
//  Description : Control unit of the BIP accumulator processor. Runs a
//                FETCH / DECODE / EXEC sequence per instruction from a start
//                pulse until HLT, then reports done and the cycle count.
//  Ports       : i_clock, i_reset (sync, active-high)
//                i_valid     - global enable, all state holds when low
//                i_start     - start pulse, honoured in IDLE or HALT
//                mem_bus     - program memory / data RAM bus (bip_if.master)
//                o_operand   - IR operand, datapath immediate
//                o_sel_a     - accumulator source select
//                o_sel_b     - ALU B source (1 immediate, 0 memory)
//                o_op_code   - ALU op (1 add, 0 subtract)
//                o_wr_acc    - accumulator write enable
//                o_busy      - high in FETCH, DECODE, EXEC
//                o_done      - high in HALT
//                o_cycles    - saturating run-cycle count since last start
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_SEL_A           = 2,
  parameter int NB_CYCLES          = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_start,
  bip_if.master                 mem_bus,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [NB_SEL_A-1:0]   o_sel_a,
  output logic                  o_sel_b,
  output logic                  o_op_code,
  output logic                  o_wr_acc,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NB_CYCLES-1:0]  o_cycles
);

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] c_pc_last =
    LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);

  state_t                        r_state,  w_next_state;
  logic [LOG2_N_INSMEM_ADDR-1:0] r_pc,     w_next_pc;
  logic [NB_DATA-1:0]            r_ir,     w_next_ir;
  logic [NB_CYCLES-1:0]          r_cycles, w_next_cycles;

  logic [LOG2_N_INSMEM_ADDR-1:0] w_pc_inc;
  logic [NB_CYCLES-1:0]          w_cycles_inc;
  logic [NB_OPCODE-1:0]          w_dec_opcode;
  ctrl_t                         w_ctrl;

  // Explicit wrap keeps the PC inside the memory even for a depth that is
  // not a power of two.
  assign w_pc_inc     = (r_pc == c_pc_last) ? '0 : r_pc + 1'b1;
  assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 1'b1;

  // In DECODE the IR is not loaded yet, so the RAM read has to be decoded
  // straight from the memory read data; in every other state IR is used.
  assign w_dec_opcode = (r_state == ST_DECODE) ?
                        mem_bus.instruction[NB_DATA-1 -: NB_OPCODE] :
                        r_ir[NB_DATA-1 -: NB_OPCODE];

  bip_decoder #(
    .NB_OPCODE (NB_OPCODE)
  ) u_decoder (
    .i_opcode (w_dec_opcode),
    .o_ctrl   (w_ctrl)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_cycles <= '0;
    end else if (i_valid) begin
      r_state  <= w_next_state;
      r_pc     <= w_next_pc;
      r_ir     <= w_next_ir;
      r_cycles <= w_next_cycles;
    end
  end

  // Next state and state-gated controls
  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_ir         = r_ir;
    w_next_cycles     = r_cycles;
    mem_bus.pc        = r_pc;
    mem_bus.data_addr = r_ir[LOG2_N_DATA_ADDR-1:0];
    mem_bus.rd_ram    = 1'b0;
    mem_bus.wr_ram    = 1'b0;
    o_wr_acc          = 1'b0;
    o_sel_a           = '0;
    o_sel_b           = 1'b0;
    o_op_code         = 1'b0;

    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          w_next_state  = ST_FETCH;
          w_next_pc     = '0;
          w_next_cycles = '0;
        end
      end
      ST_FETCH: begin
        w_next_state  = ST_DECODE;
        w_next_cycles = w_cycles_inc;
      end
      ST_DECODE: begin
        w_next_ir         = mem_bus.instruction;
        mem_bus.rd_ram    = w_ctrl.rd_ram;
        mem_bus.data_addr = mem_bus.instruction[LOG2_N_DATA_ADDR-1:0];
        w_next_state      = ST_EXEC;
        w_next_cycles     = w_cycles_inc;
      end
      ST_EXEC: begin
        o_wr_acc       = w_ctrl.wr_acc;
        o_sel_a        = NB_SEL_A'(w_ctrl.sel_a);
        o_sel_b        = w_ctrl.sel_b;
        o_op_code      = w_ctrl.op_code;
        mem_bus.wr_ram = w_ctrl.wr_ram;
        w_next_cycles  = w_cycles_inc;
        if (r_ir[NB_DATA-1 -: NB_OPCODE] == OP_HLT) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_FETCH;
          w_next_pc    = w_pc_inc;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Reset kills any enable in flight in the same cycle, so a store that
    // is being executed when reset arrives never reaches the RAM.
    if (i_reset) begin
      mem_bus.rd_ram = 1'b0;
      mem_bus.wr_ram = 1'b0;
      o_wr_acc       = 1'b0;
    end
  end

  assign o_operand = r_ir[NB_OPERAND-1:0];
  assign o_busy    = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                     (r_state == ST_EXEC);
  assign o_done    = (r_state == ST_HALT);
  assign o_cycles  = r_cycles;

endmodule : bip_control
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bip_control
//  Description : Self-checking bench for bip_control. Surrounds the control
//                unit with a program memory, a data RAM and an accumulator
//                datapath, runs small programs and compares the results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        rst, valid, start;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op_code, wr_acc, busy, done;
  logic [15:0] cycles;

  always #5 clk = ~clk;

  bip_if bus ();

  bip_control dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_valid   (valid),
    .i_start   (start),
    .mem_bus   (bus),
    .o_operand (operand),
    .o_sel_a   (sel_a),
    .o_sel_b   (sel_b),
    .o_op_code (op_code),
    .o_wr_acc  (wr_acc),
    .o_busy    (busy),
    .o_done    (done),
    .o_cycles  (cycles)
  );

  // ---------------- environment: memories and accumulator datapath --------
  logic [15:0] prog [0:2047];
  logic [15:0] ram  [0:1023];
  logic [15:0] acc, rdata, alu_b, init2, init3;

  always_comb alu_b = sel_b ? {5'b0, operand} : rdata;

  always @(posedge clk) begin
    bus.instruction <= prog[bus.pc];
    if (rst) begin
      acc    <= '0;
      rdata  <= '0;
      ram[2] <= init2;
      ram[3] <= init3;
      ram[7] <= '0;
    end else if (valid) begin
      if (bus.rd_ram) rdata <= ram[bus.data_addr];
      if (bus.wr_ram) ram[bus.data_addr] <= acc;
      if (wr_acc) begin
        case (sel_a)
          2'b00:   acc <= rdata;
          2'b01:   acc <= {5'b0, operand};
          2'b10:   acc <= op_code ? acc + alu_b : acc - alu_b;
          default: acc <= acc;
        endcase
      end
    end
  end

  // Enable activity counters, cleared by reset
  int n_rd, n_wracc, n_wrram;
  int rd_addr_q[$];
  always @(negedge clk) begin
    if (rst) begin
      n_rd = 0; n_wracc = 0; n_wrram = 0;
      rd_addr_q.delete();
    end else if (valid) begin
      if (bus.rd_ram) begin
        n_rd++;
        rd_addr_q.push_back(int'(bus.data_addr));
      end
      if (wr_acc)     n_wracc++;
      if (bus.wr_ram) n_wrram++;
    end
  end

  // ---------------- checking infrastructure -------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] ram7;
    logic [15:0] cycles;
    logic [10:0] pc;
    logic [3:0]  rd;
    logic [3:0]  wracc;
    logic [3:0]  wrram;
  } exp_t;

  typedef struct packed {
    logic [5:0][15:0] prog;
    logic [15:0]      r2;
    logic [15:0]      r3;
    exp_t             e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs [5];

  function automatic logic [15:0] ins(input logic [4:0] op, input int v);
    return {op, 11'(v)};
  endfunction

  function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, p4,
                              input int r2, r3, a, r7, cy, pc, rd, wa, wr);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
    v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = 16'h0000;
    v.r2 = 16'(r2); v.r3 = 16'(r3);
    v.e.acc = 16'(a); v.e.ram7 = 16'(r7); v.e.cycles = 16'(cy);
    v.e.pc = 11'(pc); v.e.rd = 4'(rd); v.e.wracc = 4'(wa); v.e.wrram = 4'(wr);
    return v;
  endfunction

  task automatic load_prog(input logic [5:0][15:0] p);
    for (int i = 0; i < 6; i++) prog[i] = p[i];
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done, pop the expected result and compare
  task automatic wait_and_compare(input string tag, input bit with_counts);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " done"}, longint'(seen), 1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " acc"},    acc,     e.acc);
      check({tag, " ram7"},   ram[7],  e.ram7);
      check({tag, " cycles"}, cycles,  e.cycles);
      check({tag, " pc"},     bus.pc,  e.pc);
      check({tag, " busy"},   busy,    0);
      if (with_counts) begin
        check({tag, " rd_ram count"}, n_rd,    e.rd);
        check({tag, " wr_acc count"}, n_wracc, e.wracc);
        check({tag, " wr_ram count"}, n_wrram, e.wrram);
      end
    end
  endtask

  task automatic wait_pc_change(input logic [10:0] from, input logic [10:0] want,
                                input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pc != from) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, " changed"}, longint'(ok), 1);
    check(nm, bus.pc, want);
  endtask

  // ---------------- test sequence -----------------------------------------
  initial begin
    exp_t e;
    bit   hit;
    rst = 1'b1; valid = 1'b1; start = 1'b0;
    init2 = '0; init3 = '0;
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;

    vecs[0] = mk(ins(OP_LDI, 5), ins(OP_ADDI, 3), ins(OP_STO, 7), ins(OP_HLT, 0),
                 16'h0, 0, 0, 8, 8, 12, 3, 0, 2, 1);
    vecs[1] = mk(ins(OP_LD, 2), ins(OP_SUB, 3), ins(OP_HLT, 0), 16'h0, 16'h0,
                 10, 4, 6, 0, 9, 2, 2, 2, 0);
    vecs[2] = mk(16'hF800, ins(OP_HLT, 0), 16'h0, 16'h0, 16'h0,
                 0, 0, 0, 0, 6, 1, 0, 0, 0);
    vecs[3] = mk(ins(OP_LDI, 100), ins(OP_SUBI, 1), ins(OP_ADD, 2), ins(OP_STO, 7),
                 ins(OP_HLT, 0), 10, 4, 109, 109, 15, 4, 1, 3, 1);
    vecs[4] = mk(ins(OP_LD, 3), ins(OP_ADD, 3), ins(OP_SUBI, 2), ins(OP_STO, 7),
                 ins(OP_HLT, 0), 10, 4, 6, 6, 15, 4, 2, 3, 1);

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset pc",     bus.pc, 0);
    check("reset cycles", cycles, 0);
    check("reset busy",   busy,   0);
    check("reset done",   done,   0);
    check("reset enables", {bus.rd_ram, bus.wr_ram, wr_acc, sel_a, sel_b, op_code}, 0);

    // Table-driven programs
    for (int k = 0; k < 5; k++) begin
      init2 = vecs[k].r2;
      init3 = vecs[k].r3;
      load_prog(vecs[k].prog);
      do_reset();
      sb_q.push_back(vecs[k].e);
      pulse_start();
      wait_and_compare($sformatf("vec%0d", k), 1'b1);
      if (k == 1) begin
        check("vec1 rd addr count", rd_addr_q.size(), 2);
        if (rd_addr_q.size() == 2) begin
          check("vec1 rd addr0", rd_addr_q[0], 2);
          check("vec1 rd addr1", rd_addr_q[1], 3);
        end
      end
    end

    // Restart from HALT without reset
    load_prog(vecs[0].prog);
    sb_q.push_back(vecs[0].e);
    pulse_start();
    wait_and_compare("restart", 1'b0);

    // Reset while a store is executing
    init2 = '0; init3 = '0;
    prog[0] = ins(OP_LDI, 9); prog[1] = ins(OP_STO, 7); prog[2] = ins(OP_HLT, 0);
    do_reset();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_ram) begin
        hit = 1'b1;
        break;
      end
    end
    check("sto reached exec", longint'(hit), 1);
    rst = 1'b1;
    #1 check("sto abort same cycle", bus.wr_ram, 0);
    @(posedge clk);
    #1;
    check("sto abort wr_ram", bus.wr_ram, 0);
    check("sto abort busy",   busy,       0);
    check("sto abort pc",     bus.pc,     0);
    check("sto abort cycles", cycles,     0);
    rst = 1'b0;

    // Stall in DECODE of ADDI, plus a start pulse while busy
    load_prog(vecs[0].prog);
    do_reset();
    sb_q.push_back(vecs[0].e);
    pulse_start();
    start = 1'b1;                       // in FETCH: must be ignored
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);          // now in DECODE of ADDI
    @(negedge clk);
    check("stall decode rd_ram", bus.rd_ram,    0);
    check("stall decode addr",   bus.data_addr, 3);
    check("stall cycles before", cycles,        4);
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall pc held",     bus.pc, 1);
    check("stall cycles held", cycles, 4);
    check("stall busy",        busy,   1);
    valid = 1'b1;
    wait_and_compare("stall", 1'b1);

    // PC wrap: NOPs everywhere, HLT placed at 0 once the PC has wrapped
    for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;
    do_reset();
    e = '0;
    e.cycles = 16'd6147;
    sb_q.push_back(e);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (bus.pc == 11'd2046) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap reached 2046", longint'(hit), 1);
    wait_pc_change(11'd2046, 11'd2047, "wrap pc 2047");
    wait_pc_change(11'd2047, 11'd0,    "wrap pc 0");
    prog[0] = ins(OP_HLT, 0);
    wait_and_compare("wrap", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bip_control
`default_nettype wire
